wr_pkt_admit: RTL
=================

WR_PKT_ADMIT -- requirements
Module: wr_pkt_admit

Interface
REQ-001 Parameter DATA_WIDTH, default 8, FIFO data word width.
REQ-002 Parameter PTR_WIDTH, default 4, pointer width including wrap bit; FIFO depth DEPTH = 2^(PTR_WIDTH-1); minimum 3.
REQ-003 Parameter MAX_PKT, default 4, space in words reserved per packet at admission; range 1..DEPTH.
REQ-004 Parameter AF_THRESH, default 6, almost-full level threshold; range 1..DEPTH.
REQ-005 wclk  in  1  write-domain clock; all state updates on rising edge.
REQ-006 wrst_n  in  1  reset, asynchronous, active-low.
REQ-007 s_valid  in  1  upstream beat valid.
REQ-008 s_data  in  DATA_WIDTH  upstream beat data.
REQ-009 s_last  in  1  final beat of packet; qualified by s_valid.
REQ-010 s_ready  out  1  beat consumed this cycle when s_valid & s_ready.
REQ-011 b_wptr  in  PTR_WIDTH  binary write pointer from write-pointer handler.
REQ-012 g_rptr_sync  in  PTR_WIDTH  gray read pointer, already synchronised to wclk.
REQ-013 full  in  1  FIFO full flag from write-pointer handler.
REQ-014 w_en  out  1  write request to FIFO memory and pointer handler.
REQ-015 wdata  out  DATA_WIDTH  write data, equal to s_data (combinational).
REQ-016 wlevel  out  PTR_WIDTH  registered fill level, 0..DEPTH.
REQ-017 almost_full  out  1  registered, wlevel >= AF_THRESH.
REQ-018 pkt_cnt  out  16  packets fully written, wrapping.
REQ-019 drop_cnt  out  16  packets discarded, wrapping.
REQ-020 ovf_err  out  1  sticky: w_en asserted while full.

Function
REQ-021 Gray-to-binary conversion of g_rptr_sync SHALL be combinational: rbin[MSB] = g[MSB], rbin[i] = rbin[i+1] ^ g[i].
REQ-022 Combinational level lvl = (b_wptr - rbin) modulo 2^PTR_WIDTH; free = DEPTH - lvl.
REQ-023 wlevel <= lvl and almost_full <= (lvl >= AF_THRESH) each cycle; one-cycle latency.
REQ-024 FSM states IDLE, WRITE, DROP; w_en = s_valid & s_ready & (state != DROP) & not dropping-decision.
REQ-025 IDLE: s_ready = 1; on s_valid with free >= MAX_PKT: accept (w_en = 1), go WRITE unless s_last.
REQ-026 IDLE: on s_valid with free < MAX_PKT: consume beat, w_en = 0, drop_cnt += 1, go DROP unless s_last.
REQ-027 IDLE accept with s_last (single-beat packet): pkt_cnt += 1, stay IDLE.
REQ-028 WRITE: s_ready = !full; w_en = s_valid & !full; on accepted s_last: pkt_cnt += 1, go IDLE.
REQ-029 WRITE with full asserted: stall (s_ready = 0, w_en = 0), hold state; packets longer than MAX_PKT are legal and stall this way.
REQ-030 DROP: s_ready = 1, w_en = 0; on consumed s_last go IDLE; drop_cnt not incremented again.
REQ-031 s_valid = 0 in any state: no state change, w_en = 0.
REQ-032 Admission decision uses current-cycle b_wptr/g_rptr_sync; synchroniser lag only over-estimates level (conservative).
REQ-033 ovf_err set when w_en & full; cleared only by reset.
REQ-034 Counters wrap 16'hFFFF -> 0.

Reset
REQ-035 wrst_n low asynchronously forces state IDLE, wlevel = 0, almost_full = 0, pkt_cnt = 0, drop_cnt = 0, ovf_err = 0.
REQ-036 Reset mid-packet abandons the packet; no count updated for it; remaining beats after release are treated as a new packet.

Verification
REQ-037 Reset, s_valid = 0 -> w_en = 0, s_ready = 1, all counters/flags 0.
REQ-038 b_wptr = 0, g_rptr_sync = 0, 3-beat packet 0xA1,0xA2,0xA3 -> three w_en pulses with those wdata values, pkt_cnt = 1.
REQ-039 b_wptr = 5, g_rptr_sync = 0, 2-beat packet -> free 3 < 4, w_en never high, both beats consumed, drop_cnt = 1, state returns IDLE.
REQ-040 b_wptr = 4'b0010, g_rptr_sync = 4'b1111 (bin 1010) -> next cycle wlevel = 8, almost_full = 1.
REQ-041 Level 0, 6-beat packet, full forced high on beat 5 -> s_ready = 0, w_en = 0 until full drops, then beats 5-6 written, pkt_cnt = 1.
REQ-042 wrst_n pulsed low during WRITE after 2 beats -> immediate IDLE, pkt_cnt = 0, drop_cnt = 0.

Source files
------------

// File: rtl/wr_pkt_admit.sv
// Write-side packet admission for an async FIFO.
// Each packet is admitted or discarded on its first beat, based on the free
// space seen in that cycle. The read pointer lags through the synchroniser,
// so the computed level can only be too high. The admission check is
// therefore conservative.
//
// Handshake: a beat is transferred on a rising wclk edge when
// s_valid & s_ready. s_valid may rise at any time. s_ready depends on the
// current state and 'full', and never on s_valid. s_data and s_last are
// only meaningful while s_valid is high. w_en is high only for beats that
// are consumed and written into the FIFO. Dropped beats are consumed with
// w_en low.
module wr_pkt_admit #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4,
  parameter int MAX_PKT    = 4,
  parameter int AF_THRESH  = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [PTR_WIDTH-1:0]  b_wptr,
  input  logic [PTR_WIDTH-1:0]  g_rptr_sync,
  input  logic                  full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [PTR_WIDTH-1:0]  wlevel,
  output logic                  almost_full,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           drop_cnt,
  output logic                  ovf_err,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 2 ** (PTR_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t               state;
  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] lvl;
  logic [31:0]          lvl_ext;
  logic                 admit;
  logic                 beat;

  assign wdata     = s_data;
  assign state_dbg = state;
  assign beat      = s_valid & s_ready;

  // Gray to binary conversion: bit i is the XOR of all gray bits at i and above.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rbin[i] = ^(g_rptr_sync >> i);
    end
  end

  // Fill level, and whether a packet of MAX_PKT words still fits.
  // A corrupt level above DEPTH refuses admission.
  always_comb begin
    lvl     = b_wptr - rbin;
    lvl_ext = 32'(lvl);
    admit   = (lvl_ext <= 32'(DEPTH - MAX_PKT));
  end

  // Handshake and write enable, decoded from the current state.
  always_comb begin
    s_ready = 1'b1;
    w_en    = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        w_en    = s_valid & admit;
      end
      WRITE: begin
        s_ready = ~full;
        w_en    = s_valid & ~full;
      end
      DROP: begin
        s_ready = 1'b1;
        w_en    = 1'b0;
      end
      default: begin
        s_ready = 1'b1;
        w_en    = 1'b0;
      end
    endcase
  end

  // Packet FSM with its packet and drop counters.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      pkt_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_valid) begin
            if (admit) begin
              if (s_last) pkt_cnt <= pkt_cnt + 16'd1;
              else        state   <= WRITE;
            end else begin
              drop_cnt <= drop_cnt + 16'd1;
              if (!s_last) state <= DROP;
            end
          end
        end
        WRITE: begin
          if (beat && s_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= IDLE;
          end
        end
        DROP: begin
          if (beat && s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered level view for the rest of the write domain.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel      <= '0;
      almost_full <= 1'b0;
    end else begin
      wlevel      <= lvl;
      almost_full <= (lvl_ext >= 32'(AF_THRESH));
    end
  end

  // Sticky flag: a write was issued while the FIFO reported full.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)          ovf_err <= 1'b0;
    else if (w_en & full) ovf_err <= 1'b1;
  end

endmodule
